// File: rtl/sd_dma_byte_sink.sv
// Wishbone DMA write sink: buffers {sel,dat} words in a FIFO and unpacks them to a byte stream.
// First byte valid one edge after the accepting edge; a full FIFO stalls ack, out_ready=0 holds the byte.

module sd_dma_fifo #(
   parameter int DW = 36,
   parameter int AW = 4
) (
   input  logic          clk,
   input  logic          reset_n,
   input  logic          push,
   input  logic [DW-1:0] wdat,
   input  logic          pop,
   output logic [DW-1:0] rdat,
   output logic          full,
   output logic          empty,
   output logic [AW:0]   level
);
   logic [DW-1:0] mem [0:(1<<AW)-1];
   logic [AW:0]   wr_ptr;
   logic [AW:0]   rd_ptr;
   logic          do_push;
   logic          do_pop;

   assign level   = wr_ptr - rd_ptr;
   assign full    = level[AW];
   assign empty   = (level == '0);
   assign do_push = push & ~full;
   assign do_pop  = pop & ~empty;
   assign rdat    = mem[rd_ptr[AW-1:0]];

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + {{AW{1'b0}}, 1'b1};
         if (do_pop)  rd_ptr <= rd_ptr + {{AW{1'b0}}, 1'b1};
      end
   end

   always_ff @(posedge clk) begin
      if (reset_n && do_push) mem[wr_ptr[AW-1:0]] <= wdat;
   end
endmodule

module sd_dma_byte_sink #(
   parameter int FIFO_AW     = 4,
   parameter int BLOCK_BYTES = 512
) (
   input  logic               clk,
   input  logic               reset_n,
   input  logic [31:0]        wb_adr_i,
   input  logic [31:0]        wb_dat_i,
   input  logic [3:0]         wb_sel_i,
   input  logic               wb_we_i,
   input  logic               wb_cyc_i,
   input  logic               wb_stb_i,
   output logic               wb_ack_o,
   output logic [31:0]        wb_dat_o,
   output logic [7:0]         out_data,
   output logic               out_valid,
   input  logic               out_ready,
   output logic               block_done,
   output logic [15:0]        byte_count,
   output logic [FIFO_AW:0]   fifo_level
);
   localparam logic [15:0] BLK_MASK = 16'(BLOCK_BYTES - 1);

   logic        fifo_full;
   logic        fifo_empty;
   logic [35:0] fifo_rdat;
   logic        accept;
   logic        push;
   logic        pop;
   logic        xfer;
   logic        load;
   logic [31:0] word;
   logic [3:0]  mask;
   logic [3:0]  pick;
   logic [3:0]  mask_rest;
   logic [15:0] count_next;
   logic        unused_adr;

   assign unused_adr = ^wb_adr_i;
   assign wb_dat_o   = 32'h0;

   assign accept = wb_cyc_i & wb_stb_i & ~wb_ack_o & (~wb_we_i | ~fifo_full);
   assign push   = accept & wb_we_i & (wb_sel_i != 4'h0);

   always_ff @(posedge clk) begin
      if (!reset_n) wb_ack_o <= 1'b0;
      else          wb_ack_o <= accept;
   end

   sd_dma_fifo #(.DW(36), .AW(FIFO_AW)) u_fifo (
      .clk     (clk),
      .reset_n (reset_n),
      .push    (push),
      .wdat    ({wb_sel_i, wb_dat_i}),
      .pop     (pop),
      .rdat    (fifo_rdat),
      .full    (fifo_full),
      .empty   (fifo_empty),
      .level   (fifo_level)
   );

   // Highest remaining enabled byte goes out first.
   always_comb begin
      pick     = 4'b0000;
      out_data = 8'h00;
      if (mask[3]) begin
         pick     = 4'b1000;
         out_data = word[31:24];
      end else if (mask[2]) begin
         pick     = 4'b0100;
         out_data = word[23:16];
      end else if (mask[1]) begin
         pick     = 4'b0010;
         out_data = word[15:8];
      end else if (mask[0]) begin
         pick     = 4'b0001;
         out_data = word[7:0];
      end
   end

   assign out_valid = |mask;
   assign xfer      = out_valid & out_ready;
   assign mask_rest = mask & ~pick;
   // Refill on the same edge the last byte leaves, so words stream without a bubble.
   assign load      = ~out_valid | (xfer & (mask_rest == 4'h0));
   assign pop       = load & ~fifo_empty;

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         word <= 32'h0;
         mask <= 4'h0;
      end else if (pop) begin
         word <= fifo_rdat[31:0];
         mask <= fifo_rdat[35:32];
      end else if (xfer) begin
         mask <= mask_rest;
      end
   end

   assign count_next = byte_count + 16'd1;

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         byte_count <= 16'h0;
         block_done <= 1'b0;
      end else begin
         block_done <= xfer & ((count_next & BLK_MASK) == 16'h0);
         if (xfer) byte_count <= count_next;
      end
   end
endmodule

// File: tb/tb_sd_dma_byte_sink.sv
// Randomized bench for sd_dma_byte_sink with a queue-based byte-stream reference model.
module tb_sd_dma_byte_sink;
   localparam int AW  = 4;
   localparam int BLK = 512;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic [31:0] wb_adr_i = 32'h0;
   logic [31:0] wb_dat_i = 32'h0;
   logic [3:0]  wb_sel_i = 4'h0;
   logic        wb_we_i = 1'b0;
   logic        wb_cyc_i = 1'b0;
   logic        wb_stb_i = 1'b0;
   logic        wb_ack_o;
   logic [31:0] wb_dat_o;
   logic [7:0]  out_data;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic        block_done;
   logic [15:0] byte_count;
   logic [AW:0] fifo_level;

   sd_dma_byte_sink #(.FIFO_AW(AW), .BLOCK_BYTES(BLK)) dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .wb_adr_i   (wb_adr_i),
      .wb_dat_i   (wb_dat_i),
      .wb_sel_i   (wb_sel_i),
      .wb_we_i    (wb_we_i),
      .wb_cyc_i   (wb_cyc_i),
      .wb_stb_i   (wb_stb_i),
      .wb_ack_o   (wb_ack_o),
      .wb_dat_o   (wb_dat_o),
      .out_data   (out_data),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .block_done (block_done),
      .byte_count (byte_count),
      .fifo_level (fifo_level)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Reference model: expected byte stream and emitted-byte counter.
   logic [7:0]  exp_q[$];
   logic [15:0] model_cnt = 16'h0;
   logic        prev_xfer = 1'b0;
   logic        prev_stall = 1'b0;
   logic [7:0]  prev_data = 8'h0;
   int          cyc_n = 0;
   int          bd_seen = 0;
   int          first_xfer = -1;
   int          last_xfer = -1;
   int          ack_count = 0;
   logic        rand_rdy = 1'b0;

   always @(negedge clk) begin
      cyc_n++;
      if (!reset_n) begin
         exp_q.delete();
         model_cnt  = 16'h0;
         prev_xfer  = 1'b0;
         prev_stall = 1'b0;
      end else begin
         check("byte_count", 32'(byte_count), 32'(model_cnt));
         check("block_done", 32'(block_done),
               32'(prev_xfer && ((32'(model_cnt) % BLK) == 0)));
         if (block_done) bd_seen++;
         if (prev_stall) begin
            check("stall_valid", 32'(out_valid), 32'h1);
            check("stall_data", 32'(out_data), 32'(prev_data));
         end
         prev_xfer  = out_valid & out_ready;
         prev_stall = out_valid & ~out_ready;
         prev_data  = out_data;
         if (prev_xfer) begin
            if (exp_q.size() == 0) check("spurious_byte", 32'(exp_q.size()), 32'h1);
            else                   check("byte", 32'(out_data), 32'(exp_q.pop_front()));
            model_cnt = model_cnt + 16'd1;
            if (first_xfer < 0) first_xfer = cyc_n;
            last_xfer = cyc_n;
         end
      end
   end

   always @(posedge clk) begin
      if (rand_rdy) begin
         #2;
         out_ready = 1'($urandom_range(0, 1));
      end
   end

   // All tasks begin and end 2 time units after a rising edge.
   task automatic wb_write(input logic [31:0] dat, input logic [3:0] sel, input int limit);
      int n = 0;
      wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = 1'b1;
      wb_dat_i = dat;  wb_sel_i = sel;
      forever begin
         @(negedge clk);
         if (wb_ack_o) break;
         n++;
         if (n > limit) begin
            check("write_ack_timeout", 32'(n), 32'(limit));
            break;
         end
      end
      if (wb_ack_o) begin
         ack_count++;
         for (int b = 3; b >= 0; b--)
            if (sel[b]) exp_q.push_back(dat[8*b +: 8]);
      end
      @(posedge clk); #2;
      wb_cyc_i = 1'b0; wb_stb_i = 1'b0; wb_we_i = 1'b0;
   endtask

   task automatic wb_read();
      int n = 0;
      wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = 1'b0;
      forever begin
         @(negedge clk);
         if (wb_ack_o) break;
         n++;
         if (n > 20) break;
      end
      check("read_ack", 32'(wb_ack_o), 32'h1);
      check("read_dat", wb_dat_o, 32'h0);
      @(posedge clk); #2;
      wb_cyc_i = 1'b0; wb_stb_i = 1'b0;
   endtask

   task automatic do_reset();
      reset_n = 1'b0;
      @(posedge clk); #2;
      check("rst_ack", 32'(wb_ack_o), 32'h0);
      check("rst_valid", 32'(out_valid), 32'h0);
      check("rst_block_done", 32'(block_done), 32'h0);
      check("rst_byte_count", 32'(byte_count), 32'h0);
      check("rst_fifo_level", 32'(fifo_level), 32'h0);
      check("rst_out_data", 32'(out_data), 32'h0);
      reset_n = 1'b1;
   endtask

   task automatic wait_drain();
      int n = 0;
      while ((exp_q.size() != 0 || out_valid) && n < 3000) begin
         @(negedge clk);
         n++;
      end
      @(posedge clk); #2;
      check("drain_queue", 32'(exp_q.size()), 32'h0);
      check("drain_fifo_level", 32'(fifo_level), 32'h0);
   endtask

   initial begin
      @(posedge clk); #2;
      do_reset();

      // Single full word: latency and consecutive bytes.
      out_ready = 1'b1;
      wb_write(32'h11223344, 4'hF, 20);
      check("t1_first_valid", 32'(out_valid), 32'h1);
      check("t1_first_data", 32'(out_data), 32'h11);
      check("t1_ack_one_cycle", 32'(wb_ack_o), 32'h0);
      repeat (3) begin @(posedge clk); #2; end
      check("t1_count3", 32'(byte_count), 32'h3);
      @(posedge clk); #2;
      check("t1_count4", 32'(byte_count), 32'h4);
      check("t1_idle", 32'(out_valid), 32'h0);
      wait_drain();
      check("t1_no_block_done", 32'(bd_seen), 32'h0);

      // Sparse byte enables and an all-zero sel.
      do_reset();
      wb_write(32'hAABBCCDD, 4'b0101, 20);
      check("t2_first_data", 32'(out_data), 32'hBB);
      wb_write(32'h55667788, 4'b0000, 20);
      wait_drain();
      check("t2_count", 32'(byte_count), 32'h2);

      // Fill FIFO plus unpacker with out_ready low, then drain.
      do_reset();
      out_ready = 1'b0;
      ack_count = 0;
      fork
         for (int i = 0; i < (1 << AW) + 2; i++) wb_write(32'h01020304 * (i + 1), 4'hF, 400);
         begin
            repeat (60) begin @(posedge clk); #2; end
            check("t3_acks", 32'(ack_count), 32'((1 << AW) + 1));
            check("t3_level", 32'(fifo_level), 32'(1 << AW));
            check("t3_ack_low", 32'(wb_ack_o), 32'h0);
            out_ready = 1'b1;
         end
      join
      wait_drain();
      check("t3_all_acked", 32'(ack_count), 32'((1 << AW) + 2));
      check("t3_count", 32'(byte_count), 32'(4 * ((1 << AW) + 2)));

      // One full block at full rate.
      do_reset();
      bd_seen = 0; first_xfer = -1;
      for (int i = 0; i < BLK / 4; i++) wb_write($urandom, 4'hF, 200);
      wait_drain();
      check("t4_count", 32'(byte_count), 32'(BLK));
      check("t4_block_pulses", 32'(bd_seen), 32'h1);
      check("t4_no_gaps", 32'(last_xfer - first_xfer), 32'(BLK - 1));

      // Random enables with random backpressure.
      do_reset();
      rand_rdy = 1'b1;
      for (int i = 0; i < 40; i++) wb_write($urandom, 4'($urandom_range(0, 15)), 400);
      rand_rdy = 1'b0;
      @(posedge clk); #3;
      out_ready = 1'b1;
      wait_drain();

      // Reset mid-burst with a strobe in the reset cycle.
      @(posedge clk); #2;
      do_reset();
      out_ready = 1'b0;
      for (int i = 0; i < 6; i++) wb_write($urandom, 4'hF, 50);
      check("t6_level5", 32'(fifo_level), 32'h5);
      check("t6_valid", 32'(out_valid), 32'h1);
      wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = 1'b1; wb_sel_i = 4'hF;
      do_reset();
      wb_cyc_i = 1'b0; wb_stb_i = 1'b0; wb_we_i = 1'b0;
      @(posedge clk); #2;
      check("t6_no_ack_after_rst", 32'(wb_ack_o), 32'h0);
      check("t6_level_after_rst", 32'(fifo_level), 32'h0);
      out_ready = 1'b1;
      wb_write(32'hDEADBEEF, 4'hF, 20);
      check("t6_first_data", 32'(out_data), 32'hDE);
      wait_drain();
      check("t6_count", 32'(byte_count), 32'h4);
      wb_read();
      repeat (3) begin @(posedge clk); #2; end
      check("t6_read_no_bytes", 32'(byte_count), 32'h4);
      check("t6_read_no_level", 32'(fifo_level), 32'h0);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout: got %0t expected finish earlier", $time);
      $fatal(1, "timeout");
   end
endmodule

// File: doc/sd_dma_byte_sink.md
Name: sd_dma_byte_sink

Overview:
- Wishbone classic slave on the SD controller's DMA master port (m_wb_*).
- Accepts 32-bit card-read words into an on-chip FIFO and unpacks them into a byte stream (valid/ready) for the downstream frame decoder.
- Counts emitted bytes and pulses at each SD block boundary, so the SD bus master can sequence block reads.

Parameters:
- FIFO_AW, 4: FIFO address width; depth = 2^FIFO_AW words (entry = 32 data + 4 sel bits).
- BLOCK_BYTES, 512: bytes per SD block for the block_done pulse; must be a power of two, at most 65536.

Ports:
- clk  in  1  single clock, also the wishbone clock.
- reset_n  in  1  synchronous, active-low reset.
- wb_adr_i  in  32  DMA address; ignored.
- wb_dat_i  in  32  write data from the controller.
- wb_sel_i  in  4  byte enables; bit3 corresponds to [31:24].
- wb_we_i  in  1  write enable.
- wb_cyc_i  in  1  cycle.
- wb_stb_i  in  1  strobe.
- wb_ack_o  out  1  registered acknowledge.
- wb_dat_o  out  32  read data; always 0.
- out_data  out  8  byte stream data.
- out_valid  out  1  out_data valid.
- out_ready  in  1  downstream accepts the byte.
- block_done  out  1  one-cycle pulse when a BLOCK_BYTES boundary is emitted.
- byte_count  out  16  bytes emitted since reset, modulo 2^16.
- fifo_level  out  FIFO_AW+1  words currently stored.

Behaviour:
- Reset (reset_n=0 at a clk edge):
  - wb_ack_o=0, out_valid=0, block_done=0, byte_count=0, fifo_level=0, out_data=0.
  - FIFO pointers and the unpacker are cleared, and any held word is dropped.
  - Reset mid-burst discards all data. A strobe present in the same cycle as reset is not acked.
- Wishbone accept: accept = cyc & stb & ~wb_ack_o & (~we | ~full).
  - wb_ack_o <= accept, so ack comes one cycle after the request is seen.
  - Ack is high for exactly one cycle per transfer, even when stb stays high; a held strobe is re-evaluated on the cycle after the ack.
- Write accept:
  - If sel != 0, {sel, dat} is written to the FIFO on the accepting edge.
  - If sel == 0, the write is acked and discarded.
  - While the FIFO is full, writes are stalled: no ack and no data loss. Overflow is impossible by construction.
- Read accept: acked with wb_dat_o=0 and no side effects (no card-write path).
- Simultaneous FIFO push and pop in one cycle is legal; level is unchanged. Push on full is blocked; pop on empty is blocked.
- Unpacker:
  - Holds one word plus a 4-bit remaining mask.
  - Emits the enabled bytes in order: [31:24], [23:16], [15:8], [7:0].
  - out_valid is high while any mask bit remains. out_data is the highest remaining enabled byte.
  - A transfer occurs on out_valid & out_ready; the emitted bit is cleared from the mask.
  - When the last byte transfers, or the unpacker is empty, the next FIFO word is popped on that same edge. This gives 1 byte/cycle sustained with out_ready=1 and no bubble between words.
  - out_data and out_valid hold stable while out_valid & ~out_ready.
- Latency: write accepted at edge N puts the first byte valid after edge N+1 (unpacker and FIFO empty). The FIFO provides combinational read data.
- Counters:
  - byte_count increments on every output transfer and wraps 0xFFFF to 0.
  - block_done is registered: 1 in the cycle after the transfer where (byte_count+1) mod BLOCK_BYTES == 0.
- fifo_level reflects FIFO occupancy after each edge. It excludes the word held in the unpacker.

Test Plan:
- Single write, dat=0x11223344, sel=F, out_ready=1 -> one-cycle ack; bytes 0x11,0x22,0x33,0x44 on consecutive cycles; byte_count=4; no block_done.
- Write with sel=4'b0101, dat=0xAABBCCDD -> output 0xBB then 0xDD only. A following write with sel=0 is acked and produces no bytes; byte_count=2.
- out_ready=0, 2^FIFO_AW+2 back-to-back writes with stb held high:
  - 2^FIFO_AW+1 writes are acked (FIFO plus unpacker), then ack stays low; fifo_level=2^FIFO_AW.
  - Raising out_ready drains every byte in order with no loss or duplicates, and the stalled writes then complete.
- 128 writes of sel=F with out_ready=1 -> one block_done pulse one cycle after byte 512; byte_count=512; no gaps between words.
- Random out_ready toggling during a burst -> out_data stable while stalled; emitted sequence matches the written sequence exactly.
- Assert reset_n=0 mid-burst with 5 words queued -> next cycle all outputs are at reset values and fifo_level=0. Post-reset write of 0xDEADBEEF yields DE,AD,BE,EF only. A read cycle returns wb_dat_o=0 with ack.
